// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: iterative radix-2 shift-add multiplier that sequences
// MUL / MADD / MADDU into the hi/lo register pair and stalls mfhi/mflo reads
// while an operation is still in flight.
module hilo_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MADDU = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    product;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic             op_signed;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    signed_p;
    logic [PW-1:0]    acc_sum;

    // Operand preparation and datapath arithmetic for the current cycle.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        op_signed = (op != OP_MADDU);
        rs_mag    = rs_data;
        rt_mag    = rt_data;
        if (op_signed && rs_data[WIDTH-1]) rs_mag = -rs_data;
        if (op_signed && rt_data[WIDTH-1]) rt_mag = -rt_data;
        // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
        addend    = {{WIDTH{1'b0}}, mcand} << cnt;
        signed_p  = neg ? -product : product;
        acc_sum   = {hi, lo} + signed_p;
    end

    // Sequencer FSM: accept in IDLE, one shift-add step per CALC cycle, commit in FIX.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: datapath registers are cleared too, so a reset leaves no stale operands behind.
            state   <= IDLE;
            op_q    <= OP_MUL;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && op != OP_RSVD) begin
                        mcand   <= rs_mag;
                        mplier  <= rt_mag;
                        neg     <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        op_q    <= op;
                        product <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) product <= product + addend;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (op_q == OP_MUL) {hi, lo} <= signed_p;
                    else                {hi, lo} <= acc_sum;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Front-end hold: a hi/lo read must wait while an operation is in progress.
    assign stall = hilo_read & busy;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Self-checking bench for hilo_mult_sequencer: directed vector table, hand
// sequences for multi-cycle corners, then random ops against an arithmetic model.
module tb_hilo_mult_sequencer;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hilo_read;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] model_acc;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        rd;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    hilo_mult_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .hilo_read (hilo_read),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural hi/lo value.
    function automatic logic [63:0] model_next(input logic [63:0] acc, input logic [1:0] o,
                                               input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            2'd0:    return 64'(sa * sb);
            2'd1:    return acc + 64'(sa * sb);
            2'd2:    return acc + 64'(ua * ub);
            default: return acc;
        endcase
    endfunction

    // Called at a negedge; start is seen by the next rising edge, then operands are scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Samples at each negedge until done is seen; returns at the negedge of the done cycle.
    task automatic wait_done(output int busy_n, output int stall_n, output bit held, output bit seen);
        logic [63:0] hl0;
        hl0     = {hi, lo};
        busy_n  = 0;
        stall_n = 0;
        held    = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1)  busy_n++;
            if (stall === 1'b1) stall_n++;
            if ({hi, lo} !== hl0) held = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic rd, input logic [63:0] exp,
                          input bit drop_check);
        int bn, sn;
        bit held, seen;
        hilo_read = rd;
        issue(o, a, b);
        wait_done(bn, sn, held, seen);
        check({name, " done_seen"},  64'(seen), 64'd1);
        check({name, " busy_cycles"}, 64'(bn), 64'(LAT));
        check({name, " stall_cycles"}, 64'(sn), rd ? 64'(LAT) : 64'd0);
        check({name, " hilo_held"},  64'(held), 64'd1);
        check({name, " done_cycle_busy_stall"}, {62'd0, busy, stall}, 64'd0);
        check({name, " result"}, {hi, lo}, exp);
        model_acc = exp;
        if (drop_check) begin
            @(negedge clk);
            check({name, " done_one_cycle"}, 64'(done), 64'd0);
        end
        hilo_read = 1'b0;
    endtask

    initial begin
        int          bn, sn, cnt_b, cnt_d;
        bit          held, seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic        rrd;
        logic [63:0] hl0;

        vecs[0] = '{2'd0, 32'd7,          32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h3FFF_FFFF_FFFF_FFEB};
        vecs[2] = '{2'd0, 32'd0,          32'd0,         1'b0, 64'h0};
        vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFC_0000_0002};
        vecs[5] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[6] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001};
        vecs[7] = '{2'd1, 32'hFFFF_FFFF, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[8] = '{2'd2, 32'h8000_0000, 32'd2,         1'b0, 64'h0000_0000_FFFF_FFFC};

        rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0; hilo_read = 1'b1;
        model_acc = '0;
        repeat (3) @(negedge clk);
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset busy_done_stall", {61'd0, busy, done, stall}, 64'd0);
        rst = 1'b0;
        hilo_read = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].rd, vecs[i].exp, 1'b1);

        // Start while busy is ignored; result is that of the first op.
        issue(2'd0, 32'h0000_1234, 32'h0000_0010);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; rs_data = 32'hFFFF_0000; rt_data = 32'h7FFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(bn, sn, held, seen);
        check("ignored_start done_seen", 64'(seen), 64'd1);
        check("ignored_start busy_cycles", 64'(bn), 64'(LAT - 5));
        check("ignored_start result", {hi, lo}, 64'h0000_0000_0001_2340);
        model_acc = 64'h0000_0000_0001_2340;
        @(negedge clk);
        check("ignored_start no_second_op", 64'(busy), 64'd0);

        // Reserved op: never accepted, hi/lo untouched.
        hl0 = {hi, lo};
        issue(2'd3, 32'd5, 32'd6);
        cnt_b = 0; cnt_d = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (busy === 1'b1) cnt_b++;
            if (done === 1'b1) cnt_d++;
            @(negedge clk);
        end
        check("reserved busy_cycles", 64'(cnt_b), 64'd0);
        check("reserved done_pulses", 64'(cnt_d), 64'd0);
        check("reserved hilo", {hi, lo}, hl0);

        // Back-to-back: second MUL accepted in the done cycle of the first.
        run_op("b2b_first", 2'd0, 32'd3, 32'd9, 1'b0, 64'd27, 1'b0);
        run_op("b2b_second", 2'd0, 32'hFFFF_FFFE, 32'd100, 1'b1,
               64'hFFFF_FFFF_FFFF_FF38, 1'b1);

        // Reset mid-operation aborts the op with no done pulse.
        run_op("pre_reset_clear", 2'd0, 32'd0, 32'd0, 1'b0, 64'd0, 1'b1);
        run_op("pre_reset_hi", 2'd2, 32'h2468_ACF0, 32'h8000_0000, 1'b0,
               64'h1234_5678_0000_0000, 1'b1);
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        model_acc = '0;
        cnt_d = 0; cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) cnt_d++;
            if (busy === 1'b1) cnt_b++;
            @(negedge clk);
        end
        check("midreset done_pulses", 64'(cnt_d), 64'd0);
        check("midreset busy_after", 64'(cnt_b), 64'd0);

        // Random ops against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ro  = 2'($urandom_range(0, 2));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 6 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0) rb = 32'hFFFF_FFFF;
            rrd = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ro, ra, rb, rrd,
                   model_next(model_acc, ro, ra, rb), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
